// File: rtl/ones_pattern_generator.sv
// ones_pattern_generator: streams every WIDTH-bit word with exactly k ones, in increasing order.
module ones_pattern_generator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int TZ_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] MAX_K = CNT_W'(WIDTH);
  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;
  state_t state;
  logic [CNT_W-1:0] k;
  logic [WIDTH-1:0] c, r, nxt, first_word, top_word;
  logic [TZ_W-1:0] tz;
  // Lowest set bit of c; scanning downward leaves the smallest index.
  always_comb begin
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (c[i]) tz = TZ_W'(i);
  end
  assign c          = out_word & (~out_word + 1'b1);
  assign r          = out_word + c;
  assign nxt        = r | (((r ^ out_word) >> 2) >> tz);
  assign first_word = ~({WIDTH{1'b1}} << count);
  assign top_word   = ~({WIDTH{1'b1}} >> k);
  assign out_last   = out_valid && (out_word == top_word);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (count > MAX_K) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else begin
            k         <= count;
            out_word  <= first_word;
            out_idx   <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end else begin
            out_word <= nxt;
            out_idx  <= out_idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ones_pattern_generator.sv
// tb_ones_pattern_generator: table-driven sweep of k plus reject, stall and reset sequences.
module tb_ones_pattern_generator;
  logic       clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic [3:0] count = 0;
  logic [7:0] out_word;
  logic [6:0] out_idx;
  logic       out_valid, out_last, busy, done, err;
  int         total = 0, passed = 0;
  logic [7:0] seen[$];

  ones_pattern_generator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int k; int n; logic [7:0] first; logic [7:0] last;} vec_t;
  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic stream(input int k, input bit rnd, output int n, output logic [7:0] fw, output logic [7:0] lw);
    logic [7:0] pw, top;
    bit stalled, fin;
    n = 0; fw = 0; lw = 0; pw = 0; stalled = 0; fin = 0;
    top = 8'hFF << (8 - k);
    seen.delete();
    count = 4'(k);
    start = 1;
    step();
    start = 0;
    count = 4'd9;
    check("valid_after_start", out_valid, 1);
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (stalled) check("stable_word", out_word, pw);
      else if (n > 0) check("increasing", out_word > pw, 1);
      check("popcount", $countones(out_word), k);
      check("idx", out_idx, n);
      check("last_flag", out_last, out_word == top);
      if (n == 0) fw = out_word;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        start = 1'($urandom_range(0, 1));
        count = 4'($urandom_range(0, 15));
      end
      pw = out_word;
      stalled = !out_ready;
      if (out_ready) begin
        n++;
        lw = out_word;
        seen.push_back(out_word);
        if (out_last) fin = 1;
      end
      step();
    end
    check("fin_reached", fin, 1);
    out_ready = 0;
    start = 1;
    count = 4'd1;
    check("done_pulse", done, 1);
    check("err_clear", err, 0);
    check("valid_drop", out_valid, 0);
    check("busy_in_fin", busy, 1);
    step();
    start = 0;
    check("done_one_cycle", done, 0);
    check("busy_clear", busy, 0);
    check("fin_start_ignored", out_valid, 0);
  endtask

  initial begin
    int n;
    logic [7:0] fw, lw;
    logic [7:0] k2_head[5];
    vecs[0] = '{0, 1, 8'h00, 8'h00};
    vecs[1] = '{1, 8, 8'h01, 8'h80};
    vecs[2] = '{2, 28, 8'h03, 8'hC0};
    vecs[3] = '{3, 56, 8'h07, 8'hE0};
    vecs[4] = '{4, 70, 8'h0F, 8'hF0};
    vecs[5] = '{5, 56, 8'h1F, 8'hF8};
    vecs[6] = '{6, 28, 8'h3F, 8'hFC};
    vecs[7] = '{7, 8, 8'h7F, 8'hFE};
    vecs[8] = '{8, 1, 8'hFF, 8'hFF};
    k2_head = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A};

    step();
    step();
    check("rst_word", out_word, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    step();

    for (int v = 0; v < 9; v++) begin
      stream(vecs[v].k, 0, n, fw, lw);
      check($sformatf("count_k%0d", vecs[v].k), n, vecs[v].n);
      check($sformatf("first_k%0d", vecs[v].k), fw, vecs[v].first);
      check($sformatf("last_k%0d", vecs[v].k), lw, vecs[v].last);
      if (vecs[v].k == 2)
        for (int i = 0; i < 5; i++) check("k2_head", seen[i], k2_head[i]);
    end

    count = 4'd9;
    start = 1;
    step();
    start = 0;
    check("rej_done", done, 1);
    check("rej_err", err, 1);
    check("rej_busy", busy, 0);
    check("rej_valid", out_valid, 0);
    step();
    check("rej_done_clear", done, 0);
    check("rej_err_clear", err, 0);
    check("rej_valid_idle", out_valid, 0);
    check("rej_busy_idle", busy, 0);

    stream(4, 1, n, fw, lw);
    check("rand_count_k4", n, 70);
    check("rand_last_k4", lw, 8'hF0);

    count = 4'd3;
    start = 1;
    step();
    start = 0;
    out_ready = 1;
    for (int i = 0; i < 10; i++) step();
    check("pre_rst_idx", out_idx, 10);
    rst_n = 0;
    #1;
    check("arst_word", out_word, 0);
    check("arst_valid", out_valid, 0);
    check("arst_last", out_last, 0);
    check("arst_idx", out_idx, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    out_ready = 0;
    #2;
    rst_n = 1;
    step();
    stream(8, 0, n, fw, lw);
    check("post_rst_count", n, 1);
    check("post_rst_word", fw, 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ones_pattern_generator.md
Name: ones_pattern_generator

Overview:
- Inverse companion to the team's 8-bit ones-counter.
- Takes a requested population count k and streams every WIDTH-bit word that has exactly k bits set, one word per accepted transfer, in strictly increasing numeric order.
- Drives the exhaustive-stimulus path of the ones-counter test harness and serves any consumer that needs fixed-weight codewords.
- Uses a valid/ready output handshake, a start pulse and a done pulse.

Parameters:
- WIDTH, 8, output word width; the block is verified at 8 only.
- CNT_W, 4, width of the count input; must hold the value WIDTH.
- IDX_W, 7, width of the word index; must hold C(WIDTH, WIDTH/2)-1, which is 69 for WIDTH=8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only when busy=0.
- count  in  CNT_W  requested number of ones k; sampled with start.
- out_word  out  WIDTH  current word with exactly k ones set.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  consumer accepts out_word this cycle.
- out_last  out  1  out_word is the final word of the sequence; qualified by out_valid.
- out_idx  out  IDX_W  0-based position of out_word in the sequence.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a sequence completes or is rejected.
- err  out  1  one-cycle pulse, coincident with done, when count > WIDTH.

Behaviour:
- Reset: rst_n=0 asynchronously clears all state, whether idle or mid-sequence. Reset values: state=IDLE, out_word=0, out_valid=0, out_last=0, out_idx=0, busy=0, done=0, err=0.
- States:
  - IDLE: waits for start.
  - EMIT: presents words.
  - FIN: one cycle that asserts done.
- IDLE with start=1 and count<=WIDTH:
  - Next edge: out_word=(1<<k)-1, out_idx=0, out_valid=1, busy=1, state=EMIT.
  - The latched k is held internally; later changes on count are ignored.
- IDLE with start=1 and count>WIDTH:
  - Next edge: done=1 and err=1 for one cycle.
  - No word is emitted; state stays IDLE; busy stays 0.
- start while busy=1 is ignored, with no side effects.
- EMIT:
  - out_valid stays 1.
  - out_word, out_idx and out_last stay stable while out_ready=0.
  - A transfer occurs in any cycle where out_valid and out_ready are both 1.
- Transfer when out_last=0:
  - Next edge: out_word=next(out_word), out_idx=out_idx+1.
  - Back-to-back transfers sustain one word per cycle with no bubbles.
- next(x) is the next-larger word with the same popcount:
  - c = x & -x
  - r = x + c
  - next = r | (((r ^ x) >> 2) >> ctz(c))
  - ctz is a combinational priority encoder; no divider is used.
- All arithmetic is WIDTH bits. The carry out of x+c is never used, because the last word is never advanced.
- out_last = (out_word == (((1<<k)-1) << (WIDTH-k))), i.e. the top k bits are set.
- For k=0 the single word is 0x00 and out_last=1 immediately. For k=WIDTH the single word is 0xFF and out_last=1 immediately.
- Transfer when out_last=1:
  - Next edge: out_valid=0, out_last=0, state=FIN.
  - out_word holds its final value.
- FIN:
  - done=1 for exactly one cycle, then state=IDLE and busy=0 at the next edge.
  - A start asserted during FIN is ignored.
- Latency: start to first out_valid is 1 cycle. Final transfer to done is 1 cycle. Final transfer to the next accepted start is 2 cycles.
- Total words emitted equals C(WIDTH,k); the final out_idx is C(WIDTH,k)-1.
- Invariant in every cycle where out_valid=1: popcount(out_word)==k.

Test Plan:
- k=0, out_ready=1 → exactly 1 word 0x00 with out_last=1 and out_idx=0; done 1 cycle after the transfer; err=0.
- k=1, out_ready=1 → 8 words 0x01,0x02,0x04,…,0x80 on consecutive cycles; out_last only on 0x80; out_idx 0..7.
- k=2 → first words 0x03,0x05,0x06,0x09,0x0A; 28 words total; last word 0xC0 with out_idx=27. Sweep k=0..8 and check counts 1,8,28,56,70,56,28,8,1, each word strictly increasing, and popcount==k via the ones-counter.
- count=9 → done=1 and err=1 for one cycle after start; out_valid never rises; busy stays 0.
- k=4 with out_ready toggled pseudo-randomly → out_word/out_idx stable while out_ready=0; 70 words exactly, no duplicates; start pulses while busy are ignored.
- k=3, rst_n pulled low after 10 transfers → all outputs return to reset values immediately. A new start with k=8 then yields the single word 0xFF with out_last=1.
